kypd_responder: RTL
===================

# kypd_responder

Matrix-keypad responder for the 4x4 keypad interface: it plays the keypad side of the column-scan protocol. It accepts key codes over a valid/ready port, queues them, and presses each one for a programmed time by pulling the matching ROW line low whenever the scanner drives that key's column low. It then releases the key for a programmed gap. It sits between a key source (test sequencer, PS/2 decoder, button logic) and the keypad scanner, so the maze controller can be driven without a physical keypad.

## Interface
- HOLD_CYCLES, 64, number of clock cycles a key stays pressed; must be at least 1
- GAP_CYCLES, 32, number of released cycles after each press; must be at least 1
- FIFO_DEPTH, 4, key-queue depth; power of two, at least 2
- CLK  in  1  single clock; all state updates on the rising edge
- ARSTL  in  1  reset, asynchronous, active-low
- COL  in  4  column drive from the scanner, active-low
- ROW  out  4  row sense to the scanner, active-low; 1111 means no key pressed
- KEYIN  in  4  key code to press: [3:2] is the row index, [1:0] is the column index
- KEYVALID  in  1  KEYIN is valid this cycle
- KEYREADY  out  1  queue can accept a code this cycle (equals not full)
- BUSY  out  1  high while pressing, in a gap, or while the queue is non-empty
- DONE  out  1  one-cycle pulse when a key's press and gap have completed

## Operation
- Push: a code is enqueued on a rising edge where KEYVALID && KEYREADY. When the queue is full, KEYREADY=0 and KEYVALID is ignored; no overwrite occurs.
- FSM states are IDLE, PRESS and RELEASE.
  - IDLE: if the queue is non-empty, pop the head into the key register (krow, kcol), clear the counter and go to PRESS. Otherwise stay in IDLE.
  - PRESS: the counter increments every cycle. When it reaches HOLD_CYCLES-1, clear it and go to RELEASE.
  - RELEASE: the counter increments every cycle. When it reaches GAP_CYCLES-1, clear it, go to IDLE and assert DONE on the next cycle.
- ROW is combinational from COL and state, matching physical switch behaviour:
  - In PRESS, ROW[krow] = COL[kcol] and all other bits are 1.
  - In every other state, ROW = 1111.
  - If several COL bits are low at once, only COL[kcol] matters.
- The counter width is $clog2(max(HOLD_CYCLES, GAP_CYCLES)); the counter never exceeds its terminal value.
- Simultaneous push and pop in the same cycle are both performed and the occupancy is unchanged. A push into a full queue is refused even if a pop happens in that same cycle, because KEYREADY reflects the state at the start of the cycle.
- The queue is FIFO-ordered; write and read pointers wrap modulo FIFO_DEPTH.
- The key register holds its value through PRESS and RELEASE. New pushes never disturb the key currently being pressed.

## Timing
- Reset (ARSTL=0, asynchronous) sets: state=IDLE, queue empty, counter=0, ROW=1111, DONE=0, BUSY=0, KEYREADY=1. Asserting reset mid-press releases ROW immediately and flushes the queue.
- Latency with an empty queue: push accepted at edge E0. At E1 IDLE pops and enters PRESS, so ROW can respond to COL from E1 onward.
- PRESS lasts exactly HOLD_CYCLES cycles and RELEASE exactly GAP_CYCLES cycles.
- DONE is high for the single cycle after the RELEASE to IDLE edge.
- Back-to-back keys spend exactly one cycle in IDLE between RELEASE and the next PRESS. The key period is therefore HOLD_CYCLES+GAP_CYCLES+1.
- BUSY is registered from state and queue occupancy, so it falls in the cycle after the last RELEASE ends.
- KEYREADY is combinational from the occupancy count.

## Structure
- Package kypd_pkg holds:
  - the state enum (IDLE, PRESS, RELEASE)
  - ROW_IDLE = 4'b1111
  - the key-code field positions (row field [3:2], column field [1:0])
- One sub-module, kypd_fifo: a synchronous FIFO, 4 bits wide and FIFO_DEPTH deep, with push/pop, full/empty, count and async active-low reset.
- The FSM, counter and ROW mapping stay in kypd_responder.

## Test plan
- Reset: hold ARSTL=0 with KEYVALID=1 -> ROW=1111, KEYREADY=1, BUSY=0, DONE=0, and nothing is queued after release.
- Single key: push 4'b0110 (row 1, column 2) while COL cycles 1110, 1101, 1011, 0111.
  - ROW=1101 only while COL=1011, for HOLD_CYCLES cycles starting one edge after the push.
  - Then ROW=1111 for GAP_CYCLES cycles.
  - DONE pulses once.
- Full queue: push 5 codes with FIFO_DEPTH=4 during one long press.
  - KEYREADY drops after the 4th queued code and the 5th code is held off.
  - Presses occur in push order and the period is HOLD_CYCLES+GAP_CYCLES+1.
- Simultaneous push and pop at full: KEYREADY=0 that cycle, the push is refused, the pop proceeds, and KEYREADY=1 the next cycle.
- Reset mid-press: ARSTL falls while key 4'hF is pressed with COL=0111 -> ROW=1111 immediately, the queue is empty, and the state is IDLE.
- Multi-column drive: during a press of code 4'h0, drive COL=0000 -> ROW=1110; drive COL=1110 -> ROW=1110; drive COL=1101 -> ROW=1111.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared types and constants for the keypad responder.
package kypd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      RELEASE = 2'd2
   } kypd_state_e;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // Key code layout: row index in the upper pair, column index in the lower pair.
   localparam int unsigned KEY_ROW_MSB = 3;
   localparam int unsigned KEY_ROW_LSB = 2;
   localparam int unsigned KEY_COL_MSB = 1;
   localparam int unsigned KEY_COL_LSB = 0;

   // Counter width covering both the hold and gap terminal values; never zero.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/kypd_fifo.sv
// Synchronous key-code queue; push is ignored when full, pop ignored when empty.
module kypd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_arst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage array; contents need no reset since occupancy guards every read.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: rtl/kypd_responder.sv
// Keypad-side model of a 4x4 matrix: presses queued keys against the scanner's column drive.
module kypd_responder
   import kypd_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 64,
   parameter int unsigned GAP_CYCLES  = 32,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       CLK,
   input  logic       ARSTL,
   input  logic [3:0] COL,
   output logic [3:0] ROW,
   input  logic [3:0] KEYIN,
   input  logic       KEYVALID,
   output logic       KEYREADY,
   output logic       BUSY,
   output logic       DONE
);

   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   kypd_state_e                  r_state;
   kypd_state_e                  w_state_nxt;
   logic [CNT_W-1:0]             r_cnt;
   logic [CNT_W-1:0]             w_cnt_nxt;
   logic [1:0]                   r_krow;
   logic [1:0]                   r_kcol;
   logic                         r_done;
   logic                         w_done_nxt;
   logic                         r_busy;
   logic                         w_pop;
   logic [3:0]                   w_fifo_data;
   logic                         w_full;
   logic                         w_empty;
   logic [$clog2(FIFO_DEPTH):0]  w_count;
   logic [3:0]                   w_row;

   kypd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_fifo (
      .i_clk    (CLK),
      .i_arst_n (ARSTL),
      .i_push   (KEYVALID),
      .i_data   (KEYIN),
      .i_pop    (w_pop),
      .o_data   (w_fifo_data),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_count  (w_count)
   );

   assign KEYREADY = !w_full;
   assign BUSY     = r_busy;
   assign DONE     = r_done;

   // Next-state, counter and pop decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = PRESS;
            end
         end
         PRESS: begin
            if (r_cnt == HOLD_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = RELEASE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (r_cnt == GAP_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, counter, key register and registered status flags.
   always_ff @(posedge CLK or negedge ARSTL) begin
      if (!ARSTL) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_krow  <= '0;
         r_kcol  <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= (r_state != IDLE) || (w_count != '0);
         if (w_pop) begin
            r_krow <= w_fifo_data[KEY_ROW_MSB:KEY_ROW_LSB];
            r_kcol <= w_fifo_data[KEY_COL_MSB:KEY_COL_LSB];
         end
      end
   end

   // Switch model: the pressed key connects its column to its row, nothing else conducts.
   always_comb begin
      w_row = ROW_IDLE;
      if (r_state == PRESS) begin
         w_row[r_krow] = COL[r_kcol];
      end
   end

   assign ROW = w_row;

endmodule
